// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the divide-by-zero quotient.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// 32 shift-add / restoring-divide steps, then one sign-fix cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWen,
  input  logic             loWen,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state;
  mdu_op_e          opq;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [W2-1:0]    acc;
  logic [CW-1:0]    cnt;

  function automatic logic [WIDTH-1:0] cneg(
    input logic             n,
    input logic [WIDTH-1:0] x
  );
    return n ? (~x + 1'b1) : x;
  endfunction

  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    in_sa = op[0] & srcA[WIDTH-1];
    in_sb = op[0] & srcB[WIDTH-1];
    abs_a = cneg(in_sa, srcA);
    abs_b = cneg(in_sb, srcB);
  end

  logic             is_div;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   sub;
  logic [W2-1:0]    shl;
  logic [W2-1:0]    step_n;

  always_comb begin
    is_div = (opq == MDU_DIVU) || (opq == MDU_DIV);
    add = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opa};
    shl = {acc[W2-2:0], 1'b0};
    sub = {1'b0, shl[W2-1:WIDTH]} - {1'b0, opb};
    if (is_div) begin
      if (sub[WIDTH])
        step_n = shl;
      else
        step_n = {sub[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      if (acc[0])
        step_n = {add, acc[WIDTH-1:1]};
      else
        step_n = {1'b0, acc[W2-1:1]};
    end
  end

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    prod = (opq == MDU_MULT && (sa ^ sb)) ? (~acc + 1'b1) : acc;
    if (!is_div) begin
      res_hi = prod[W2-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (opb == '0) begin
      // sa is only set for DIV, so this rebuilds the raw dividend
      res_hi = cneg(sa, opa);
      res_lo = DIV0_QUOT;
    end else begin
      res_hi = cneg(opq == MDU_DIV && sa, acc[W2-1:WIDTH]);
      res_lo = cneg(opq == MDU_DIV && (sa ^ sb), acc[WIDTH-1:0]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      opq   <= MDU_MULTU;
      sa    <= 1'b0;
      sb    <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hiWen) hi <= writeData;
          if (loWen) lo <= writeData;
          if (start) begin
            opq   <= mdu_op_e'(op);
            sa    <= in_sa;
            sb    <= in_sb;
            opa   <= abs_a;
            opb   <= abs_b;
            acc   <= op[1] ? {{WIDTH{1'b0}}, abs_a}
                           : {{WIDTH{1'b0}}, abs_b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= step_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Directed corners plus random ops against a plain-arithmetic model.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        hiWen = 1'b0;
  logic        loWen = 1'b0;
  logic [31:0] writeData = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  // done is visible just after edge 33 = sampled at edge 34
  localparam int DONE_LAT = 33;
  localparam int LAT_MAX = 60;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .start(start),
    .op(op),
    .srcA(srcA),
    .srcB(srcB),
    .hiWen(hiWen),
    .loWen(loWen),
    .writeData(writeData),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint unsigned ua;
    longint unsigned ub;
    longint          xa;
    longint          xb;
    longint          q;
    longint          r;
    ua = {32'b0, a};
    ub = {32'b0, b};
    xa = longint'(signed'(a));
    xb = longint'(signed'(b));
    case (o)
      2'b00: return ua * ub;
      2'b01: return 64'(xa * xb);
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = xa / xb;
        r = xa % xb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  task automatic issue(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    op = o;
    srcA = a;
    srcB = b;
    start = 1'b1;
  endtask

  // Call #1 after the launch edge; counts edges until done shows.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < LAT_MAX) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rh,
    output logic [31:0] rl,
    output int          lat
  );
    @(posedge Clk);
    #1;
    issue(o, a, b);
    @(posedge Clk);
    #1;
    start = 1'b0;
    srcA = $urandom;
    srcB = $urandom;
    op = 2'($urandom);
    wait_done(lat);
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want all 0",
               busy, done, hi, lo);
    end
    Rst = 1'b0;
  endtask

  task automatic test_latency;
    int lat;
    int bad_busy;
    bad_busy = 0;
    @(posedge Clk);
    #1;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge Clk);
    #1;
    start = 1'b0;
    srcA = 32'h1;
    srcB = 32'h1;
    lat = 0;
    if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
    while (!done && lat < LAT_MAX) begin
      @(posedge Clk);
      #1;
      lat++;
      if (!done && (busy !== 1'b1)) bad_busy++;
    end
    checks++;
    if (lat != DONE_LAT) begin
      failures++;
      $display("FAIL latency: got %0d want %0d", lat, DONE_LAT);
    end
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_window: errs=%0d busy_at_done=%b want 0/0",
               bad_busy, busy);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL multu_max: got %h%h want fffffffe00000001", hi, lo);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b want 0 next cycle", done);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  to [7];
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [63:0] te [7];
    logic [31:0] rh;
    logic [31:0] rl;
    int          lat;
    to = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
    ta = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
           32'h8000_0000, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
    tb = '{32'd7, 32'h8000_0000, 32'd2, 32'd3, 32'd0,
           32'hFFFF_FFFF, 32'd0};
    te = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_2AAA_AAAA,
           64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000,
           64'hFFFF_FFF9_FFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      run_op(to[i], ta[i], tb[i], rh, rl, lat);
      checks++;
      if ({rh, rl} !== te[i] || lat != DONE_LAT) begin
        failures++;
        $display("FAIL directed%0d: got %h%h lat=%0d want %h lat=%0d",
                 i, rh, rl, lat, te[i], DONE_LAT);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rh;
    logic [31:0] rl;
    logic [63:0] exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp = model(o, a, b);
      run_op(o, a, b, rh, rl, lat);
      checks++;
      if ({rh, rl} !== exp || lat != DONE_LAT) begin
        failures++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got %h%h lat=%0d want %h",
                 i, o, a, b, rh, rl, lat, exp);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] hi_before;
    int          lat;
    @(posedge Clk);
    #1;
    issue(2'b00, 32'd3, 32'd4);
    @(posedge Clk);
    #1;
    start = 1'b0;
    hi_before = hi;
    repeat (4) @(posedge Clk);
    #1;
    issue(2'b10, 32'd99, 32'd7);
    hiWen = 1'b1;
    writeData = 32'h1234;
    @(posedge Clk);
    #1;
    start = 1'b0;
    hiWen = 1'b0;
    checks++;
    if (hi !== hi_before) begin
      failures++;
      $display("FAIL mthi_busy: hi=%h want %h", hi, hi_before);
    end
    wait_done(lat);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12 || lat != DONE_LAT - 5) begin
      failures++;
      $display("FAIL start_busy: got %h/%h lat=%0d want 0/c lat=%0d",
               hi, lo, lat, DONE_LAT - 5);
    end
    // back-to-back: launch in the done cycle
    issue(2'b00, 32'd2, 32'd2);
    @(posedge Clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lo !== 32'd4 || hi !== 32'd0 || lat != DONE_LAT) begin
      failures++;
      $display("FAIL b2b_result: got %h/%h lat=%0d want 0/4 lat=%0d",
               hi, lo, lat, DONE_LAT);
    end
  endtask

  task automatic test_mt;
    int lat;
    @(posedge Clk);
    #1;
    hiWen = 1'b1;
    writeData = 32'hAAAA_0000;
    @(posedge Clk);
    #1;
    hiWen = 1'b0;
    loWen = 1'b1;
    writeData = 32'h0000_BBBB;
    @(posedge Clk);
    #1;
    loWen = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_BBBB) begin
      failures++;
      $display("FAIL mthi_mtlo: got %h/%h want aaaa0000/0000bbbb", hi, lo);
    end
    hiWen = 1'b1;
    loWen = 1'b1;
    writeData = 32'h5A5A_A5A5;
    issue(2'b00, 32'd6, 32'd7);
    @(posedge Clk);
    #1;
    hiWen = 1'b0;
    loWen = 1'b0;
    start = 1'b0;
    checks++;
    if (hi !== 32'h5A5A_A5A5 || lo !== 32'h5A5A_A5A5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mt_with_start: got %h/%h busy=%b want 5a5aa5a5 x2 busy=1",
               hi, lo, busy);
    end
    wait_done(lat);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL mt_overwrite: got %h/%h want 0/2a", hi, lo);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(posedge Clk);
    #1;
    hiWen = 1'b1;
    loWen = 1'b1;
    writeData = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    hiWen = 1'b0;
    loWen = 1'b0;
    issue(2'b10, 32'd1000, 32'd7);
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      failures++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_quiet: active=%0d hi=%h lo=%h want 0", seen, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_busy_ignore();
    test_mt();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
